// File: rtl/enkel_core_p.sv
// enkel_core_p: parametrised accumulator CPU with a handshaked memory port,
// a blocking input port (GET), an output strobe (SHOW), conditional jump and HALT.
module enkel_core_p #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              master_reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] show_out,
  output logic              show_valid,
  output logic              carry,
  output logic              status,
  output logic              halted
);

  localparam int unsigned OP_W = 3;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  localparam logic [OP_W-1:0] OP_LD   = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b010;
  localparam logic [OP_W-1:0] OP_PUT  = 3'b011;
  localparam logic [OP_W-1:0] OP_GET  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHOW = 3'b101;
  localparam logic [OP_W-1:0] OP_JMPC = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_ARG,
    S_MEM_OP,
    S_EXEC,
    S_GET_WAIT,
    S_HALT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [OP_W-1:0]   ir, ir_n;
  logic [ADDR_W-1:0] operand, operand_n;
  logic              carry_n;
  logic [DATA_W-1:0] show_n;
  logic              show_valid_n;
  logic              req_n, we_n, in_ready_n, status_n, halted_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  logic              xfer_c;
  logic [OP_W-1:0]   rd_op_c;
  logic [DATA_W:0]   sum_c;

  assign xfer_c  = mem_req & mem_ack;
  assign rd_op_c = mem_rdata[DATA_W-1 -: OP_W];
  assign sum_c   = {1'b0, acc} + {1'b0, mem_rdata};

  // State and datapath registers; bus/handshake outputs are registered from next-state values
  always_ff @(posedge clk or posedge master_reset) begin
    if (master_reset) begin
      state      <= S_IDLE;
      pc         <= PC_INIT;
      acc        <= '0;
      ir         <= '0;
      operand    <= '0;
      carry      <= 1'b0;
      show_out   <= '0;
      show_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      in_ready   <= 1'b0;
      status     <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      acc        <= acc_n;
      ir         <= ir_n;
      operand    <= operand_n;
      carry      <= carry_n;
      show_out   <= show_n;
      show_valid <= show_valid_n;
      mem_req    <= req_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      in_ready   <= in_ready_n;
      status     <= status_n;
      halted     <= halted_n;
    end
  end

  // Next-state, datapath and next bus request
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    acc_n        = acc;
    ir_n         = ir;
    operand_n    = operand;
    carry_n      = carry;
    show_n       = show_out;
    show_valid_n = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH_OP;
          pc_n    = PC_INIT;
        end
      end
      S_FETCH_OP: begin
        if (xfer_c) begin
          ir_n = rd_op_c;
          pc_n = pc + ADDR_W'(1);
          case (rd_op_c)
            OP_LD, OP_ADD, OP_PUT, OP_JMPC: state_n = S_FETCH_ARG;
            OP_GET:                         state_n = S_GET_WAIT;
            OP_HALT:                        state_n = S_HALT;
            default:                        state_n = S_EXEC;
          endcase
        end
      end
      S_FETCH_ARG: begin
        if (xfer_c) begin
          operand_n = mem_rdata[ADDR_W-1:0];
          pc_n      = pc + ADDR_W'(1);
          state_n   = (ir == OP_JMPC) ? S_EXEC : S_MEM_OP;
        end
      end
      S_MEM_OP: begin
        if (xfer_c) begin
          if (ir == OP_LD) begin
            acc_n = mem_rdata;
          end else if (ir == OP_ADD) begin
            {carry_n, acc_n} = sum_c;
          end
          state_n = S_FETCH_OP;
        end
      end
      S_EXEC: begin
        case (ir)
          OP_NOT: acc_n = ~acc;
          OP_SHOW: begin
            show_n       = acc;
            show_valid_n = 1'b1;
          end
          OP_JMPC: begin
            if (carry) pc_n = operand;
            carry_n = 1'b0;
          end
          default: ;
        endcase
        state_n = S_FETCH_OP;
      end
      S_GET_WAIT: begin
        if (in_valid && in_ready) begin
          acc_n   = in_data;
          state_n = S_FETCH_OP;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A pending request keeps its state, PC and operand, so the bus holds steady until ack
    req_n      = (state_n == S_FETCH_OP) || (state_n == S_FETCH_ARG) || (state_n == S_MEM_OP);
    we_n       = (state_n == S_MEM_OP) && (ir_n == OP_PUT);
    addr_n     = (state_n == S_MEM_OP) ? operand_n : pc_n;
    wdata_n    = acc_n;
    in_ready_n = (state_n == S_GET_WAIT);
    status_n   = (state_n != S_IDLE) && (state_n != S_HALT);
    halted_n   = (state_n == S_HALT);
  end

endmodule

// File: tb/tb_enkel_core_p.sv
// Directed bench for enkel_core_p: an 8-bit core with a wait-state memory model
// and a 16/12-bit core exercising PC wrap and wide carry.
module tb_enkel_core_p;

  logic        clk = 1'b0;
  logic        master_reset;
  logic        start, start2;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  show_out;
  logic        show_valid, carry, status, halted;

  logic        mem_req2, mem_we2, mem_ack2;
  logic [11:0] mem_addr2;
  logic [15:0] mem_wdata2, mem_rdata2;
  logic [15:0] in_data2;
  logic        in_valid2, in_ready2;
  logic [15:0] show_out2;
  logic        show_valid2, carry2, status2, halted2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enkel_core_p dut (
    .clk(clk), .master_reset(master_reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .show_out(show_out), .show_valid(show_valid), .carry(carry),
    .status(status), .halted(halted)
  );

  enkel_core_p #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'hFFE)) dut2 (
    .clk(clk), .master_reset(master_reset), .start(start2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .show_out(show_out2), .show_valid(show_valid2), .carry(carry2),
    .status(status2), .halted(halted2)
  );

  // Memory models: program images are copied in by the negedge process, writes committed there too
  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic [15:0] mem2 [4096];
  logic [15:0] img2 [4096];
  int          img_seq = 0, img_seen = 0, img2_seq = 0, img2_seen = 0;
  int          wait_cfg = 0, wcnt = 0;
  logic        tie_ack = 1'b1;
  logic        fired, wr_v, wr2_v;
  logic [7:0]  wr_a, wr_d;
  logic [11:0] wr2_a;
  logic [15:0] wr2_d;
  int          show_total = 0, show2_total = 0;

  always @(posedge clk) begin
    fired = mem_req && mem_ack;
    wr_v  = fired && mem_we;
    wr_a  = mem_addr;
    wr_d  = mem_wdata;
    wr2_v = mem_req2 && mem_ack2 && mem_we2;
    wr2_a = mem_addr2;
    wr2_d = mem_wdata2;
    if (show_valid)  show_total++;
    if (show_valid2) show2_total++;
  end

  always @(negedge clk) begin
    if (img_seq != img_seen) begin mem = img; img_seen = img_seq; end
    if (img2_seq != img2_seen) begin mem2 = img2; img2_seen = img2_seq; end
    if (wr_v) mem[wr_a] = wr_d;
    if (wr2_v) mem2[wr2_a] = wr2_d;
    if (mem_req) begin
      if (wcnt >= wait_cfg) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr]; wcnt = 0;
      end else begin
        mem_ack = 1'b0; wcnt++;
      end
    end else begin
      mem_ack = tie_ack; wcnt = 0;
    end
    mem_ack2   = mem_req2;
    mem_rdata2 = mem2[mem_addr2];
  end

  task automatic clear_img;
    foreach (img[i]) img[i] = 8'h00;
  endtask

  task automatic load_img;
    img_seq++;
    repeat (2) @(negedge clk);
  endtask

  // LD 10; ADD 11; PUT 12; SHOW; HALT with 5 and 7 as data
  task automatic basic_prog;
    clear_img();
    img[8'h00] = 8'h00; img[8'h01] = 8'h10;
    img[8'h02] = 8'h20; img[8'h03] = 8'h11;
    img[8'h04] = 8'h60; img[8'h05] = 8'h12;
    img[8'h06] = 8'hA0; img[8'h07] = 8'hE0;
    img[8'h10] = 8'h05; img[8'h11] = 8'h07;
    load_img();
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_prog(input int budget, input bit mid_start, output int cycles);
    pulse_start();
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk); cycles++; #1;
      start = mid_start && (cycles == 5);
      if (halted) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    master_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({status, halted, carry} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {status, halted, carry}); end
    n_cmp++; if ({show_out, show_valid, in_ready} !== 10'h000) begin n_bad++; $display("FAIL reset_show: got %h want 000", {show_out, show_valid, in_ready}); end
    n_cmp++; if ({mem_req2, status2, halted2, carry2} !== 4'b0000) begin n_bad++; $display("FAIL reset_wide: got %b want 0000", {mem_req2, status2, halted2, carry2}); end
    @(negedge clk); master_reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, s0;
    wait_cfg = 0; tie_ack = 1'b1;
    basic_prog();
    s0 = show_total;
    run_prog(100, 1'b0, cyc);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL basic_cycles: got %0d want 12", cyc); end
    n_cmp++; if (mem[8'h12] !== 8'h0C) begin n_bad++; $display("FAIL basic_put: got %h want 0c", mem[8'h12]); end
    n_cmp++; if (show_out !== 8'h0C) begin n_bad++; $display("FAIL basic_show: got %h want 0c", show_out); end
    n_cmp++; if (show_total - s0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", show_total - s0); end
    n_cmp++; if ({carry, halted, status} !== 3'b010) begin n_bad++; $display("FAIL basic_flags: got %b want 010", {carry, halted, status}); end
  endtask

  task automatic test_carry_jmpc;
    int cyc;
    clear_img();
    img[8'h00] = 8'h00; img[8'h01] = 8'h10;
    img[8'h02] = 8'h20; img[8'h03] = 8'h11;
    img[8'h04] = 8'hC0; img[8'h05] = 8'h20;
    img[8'h06] = 8'hA0; img[8'h07] = 8'hE0;
    img[8'h20] = 8'h40; img[8'h21] = 8'hA0; img[8'h22] = 8'hE0;
    img[8'h10] = 8'hF0; img[8'h11] = 8'h20;
    load_img();
    // Taken: F0+20 -> 10 with carry, jump to NOT/SHOW shows EF; stray start mid-run ignored
    run_prog(100, 1'b1, cyc);
    n_cmp++; if (cyc !== 14) begin n_bad++; $display("FAIL jmpc_taken_cycles: got %0d want 14", cyc); end
    n_cmp++; if (show_out !== 8'hEF) begin n_bad++; $display("FAIL jmpc_taken_show: got %h want ef", show_out); end
    n_cmp++; if (carry !== 1'b0) begin n_bad++; $display("FAIL jmpc_clears_carry: got %b want 0", carry); end
    // Not taken: F0+01 = F1, no carry, falls through to SHOW
    img[8'h11] = 8'h01;
    load_img();
    run_prog(100, 1'b0, cyc);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL jmpc_fall_cycles: got %0d want 12", cyc); end
    n_cmp++; if (show_out !== 8'hF1) begin n_bad++; $display("FAIL jmpc_fall_show: got %h want f1", show_out); end
    // Carry survives into HALT: LD; ADD (overflow); PUT 14; HALT
    img[8'h11] = 8'h20;
    img[8'h04] = 8'h60; img[8'h05] = 8'h14; img[8'h06] = 8'hE0;
    load_img();
    run_prog(100, 1'b0, cyc);
    n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL ovf_cycles: got %0d want 10", cyc); end
    n_cmp++; if (mem[8'h14] !== 8'h10) begin n_bad++; $display("FAIL ovf_sum: got %h want 10", mem[8'h14]); end
    n_cmp++; if ({carry, halted} !== 2'b11) begin n_bad++; $display("FAIL ovf_carry_halt: got %b want 11", {carry, halted}); end
  endtask

  task automatic test_wait_states;
    int cyc, s0, holds;
    logic       prev_req, prev_we;
    logic [7:0] prev_addr, prev_wdata;
    wait_cfg = 3; tie_ack = 1'b0;
    basic_prog();
    s0 = show_total;
    pulse_start();
    prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
    cyc = 0; holds = 0;
    while (cyc < 300) begin
      @(posedge clk); cyc++; #1;
      if (prev_req && !fired) begin
        holds++;
        n_cmp++;
        if ({mem_req, mem_addr, mem_we, mem_wdata} !== {1'b1, prev_addr, prev_we, prev_wdata}) begin
          n_bad++;
          $display("FAIL wait_hold: got req=%b addr=%h we=%b wd=%h want req=1 addr=%h we=%b wd=%h",
                   mem_req, mem_addr, mem_we, mem_wdata, prev_addr, prev_we, prev_wdata);
        end
      end
      prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
      if (halted) break;
    end
    n_cmp++; if (cyc !== 45) begin n_bad++; $display("FAIL wait_cycles: got %0d want 45", cyc); end
    n_cmp++; if (holds !== 33) begin n_bad++; $display("FAIL wait_hold_count: got %0d want 33", holds); end
    n_cmp++; if (mem[8'h12] !== 8'h0C) begin n_bad++; $display("FAIL wait_put: got %h want 0c", mem[8'h12]); end
    n_cmp++; if (show_out !== 8'h0C || show_total - s0 !== 1) begin n_bad++; $display("FAIL wait_show: got %h/%0d want 0c/1", show_out, show_total - s0); end
    n_cmp++; if ({carry, halted} !== 2'b01) begin n_bad++; $display("FAIL wait_flags: got %b want 01", {carry, halted}); end
  endtask

  task automatic test_get;
    int n, ready_cycles, bad_req, s0;
    wait_cfg = 0; tie_ack = 1'b1;
    clear_img();
    img[8'h00] = 8'h80; img[8'h01] = 8'hA0; img[8'h02] = 8'hE0;
    load_img();
    s0 = show_total;
    in_valid = 1'b0; in_data = 8'h00;
    pulse_start();
    ready_cycles = 0; bad_req = 0;
    for (n = 0; n < 60 && !halted; n++) begin
      @(negedge clk);
      if (in_valid) begin
        in_valid = 1'b0;
      end else if (in_ready) begin
        ready_cycles++;
        if (mem_req) bad_req++;
        if (ready_cycles == 6) begin in_valid = 1'b1; in_data = 8'hA5; end
      end
    end
    n_cmp++; if (ready_cycles !== 6) begin n_bad++; $display("FAIL get_ready_cycles: got %0d want 6", ready_cycles); end
    n_cmp++; if (bad_req !== 0) begin n_bad++; $display("FAIL get_no_req: got %0d want 0", bad_req); end
    n_cmp++; if (show_out !== 8'hA5 || show_total - s0 !== 1) begin n_bad++; $display("FAIL get_value: got %h/%0d want a5/1", show_out, show_total - s0); end
    n_cmp++; if ({halted, in_ready} !== 2'b10) begin n_bad++; $display("FAIL get_end: got %b want 10", {halted, in_ready}); end
  endtask

  task automatic test_reset_mid_put;
    int n, cyc;
    wait_cfg = 3; tie_ack = 1'b0;
    basic_prog();
    pulse_start();
    for (n = 0; n < 200 && !(mem_req && mem_we); n++) @(negedge clk);
    n_cmp++; if (!(mem_req && mem_we)) begin n_bad++; $display("FAIL rst_put_seen: got req=%b we=%b want 1 1", mem_req, mem_we); end
    master_reset = 1'b1;
    #1;
    n_cmp++; if ({mem_req, status, halted, carry} !== 4'b0000) begin n_bad++; $display("FAIL rst_async: got %b want 0000", {mem_req, status, halted, carry}); end
    repeat (2) @(negedge clk);
    master_reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem[8'h12] !== 8'h00) begin n_bad++; $display("FAIL rst_aborted_put: got %h want 00", mem[8'h12]); end
    n_cmp++; if (show_out !== 8'h00) begin n_bad++; $display("FAIL rst_show: got %h want 00", show_out); end
    wait_cfg = 0; tie_ack = 1'b1;
    run_prog(100, 1'b0, cyc);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL rst_rerun_cycles: got %0d want 12", cyc); end
    n_cmp++; if (mem[8'h12] !== 8'h0C || show_out !== 8'h0C) begin n_bad++; $display("FAIL rst_rerun: got %h/%h want 0c/0c", mem[8'h12], show_out); end
  endtask

  task automatic test_wide;
    int cyc;
    foreach (img2[i]) img2[i] = 16'h0000;
    img2[12'hFFE] = 16'h0000; img2[12'hFFF] = 16'hF100;
    img2[12'h000] = 16'h2000; img2[12'h001] = 16'h0101;
    img2[12'h002] = 16'h6000; img2[12'h003] = 16'h0102;
    img2[12'h004] = 16'hE000;
    img2[12'h100] = 16'h8001; img2[12'h101] = 16'h8000;
    img2_seq++;
    repeat (2) @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n_cmp++; if ({mem_req2, mem_addr2} !== {1'b1, 12'hFFE}) begin n_bad++; $display("FAIL wide_first_fetch: got %b/%h want 1/ffe", mem_req2, mem_addr2); end
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); cyc++; #1;
      if (halted2) break;
    end
    n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL wide_cycles: got %0d want 10", cyc); end
    n_cmp++; if (mem2[12'h102] !== 16'h0001) begin n_bad++; $display("FAIL wide_sum: got %h want 0001", mem2[12'h102]); end
    n_cmp++; if ({carry2, halted2, status2} !== 3'b110) begin n_bad++; $display("FAIL wide_flags: got %b want 110", {carry2, halted2, status2}); end
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0;
    in_data = 8'h00; in_valid = 1'b0;
    in_data2 = 16'h0000; in_valid2 = 1'b0;
    test_reset();
    test_basic();
    test_carry_jmpc();
    test_wait_states();
    test_get();
    test_reset_mid_put();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
